writeback_queue: RTL and testbench

Buffers register-file write requests from the ALU and memory result paths and drains them, one per cycle, into the single write port of the 32×64-bit register file. It sits between the execute/memory stages and the regfile write port, accepting up to two results per cycle with valid/ready handshakes. Writes to X31 (hard-wired zero) are discarded, and in-flight data can optionally be forwarded to the regfile read ports.

---
 rtl/wbq_pkg.sv | 19 +
 rtl/wbq_fifo.sv | 61 ++++++
 rtl/writeback_queue.sv | 161 ++++++++++++++++
 tb/tb_writeback_queue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/wbq_pkg.sv
// wbq_pkg: shared types and constants for the register-file writeback queue.
//   wb_entry_t : one pending write {reg_idx, data} at the default widths
//   ZERO_REG   : index of the hard-wired zero register; writes to it are dropped
//   WBQ_*      : default parameter values for writeback_queue
package wbq_pkg;

  localparam int WBQ_DEPTH  = 4;
  localparam int WBQ_DATA_W = 64;
  localparam int WBQ_ADDR_W = 5;

  localparam logic [WBQ_ADDR_W-1:0] ZERO_REG = 5'd31;

  // "reg" is a keyword, so the destination index field is called reg_idx.
  typedef struct packed {
    logic [WBQ_ADDR_W-1:0] reg_idx;
    logic [WBQ_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_fifo.sv
// wbq_fifo: circular buffer with up to two pushes and one pop per cycle.
//   wr_cnt         : number of entries pushed this cycle (0..2); wr_data0 is
//                    stored first, wr_data1 second
//   pop            : remove the head entry (caller only pops when count != 0)
//   head_data      : oldest entry
//   head_ptr       : index of the oldest entry inside entries
//   count          : occupied entries
//   entries        : raw storage, for associative lookups by the owner
// Pointers are $clog2(DEPTH) bits wide, so they wrap modulo DEPTH on their own.
module wbq_fifo import wbq_pkg::*; #(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int W     = WBQ_ADDR_W + WBQ_DATA_W,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            wr_cnt,
  input  logic [W-1:0]          wr_data0,
  input  logic [W-1:0]          wr_data1,
  input  logic                  pop,
  output logic [W-1:0]          head_data,
  output logic [PW-1:0]         head_ptr,
  output logic [CW-1:0]         count,
  output logic [DEPTH-1:0][W-1:0] entries
);

  logic [PW-1:0]          head_r;
  logic [PW-1:0]          tail_r;
  logic [CW-1:0]          count_r;
  logic [DEPTH-1:0][W-1:0] mem_r;
  logic [PW-1:0]          tail_p1_s;

  assign tail_p1_s = tail_r + PW'(1'b1);

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      mem_r   <= '0;
    end else begin
      if (wr_cnt != 2'd0) begin
        mem_r[tail_r] <= wr_data0;
      end
      if (wr_cnt == 2'd2) begin
        mem_r[tail_p1_s] <= wr_data1;
      end
      tail_r  <= tail_r + PW'(wr_cnt);
      head_r  <= head_r + PW'(pop);
      count_r <= count_r + CW'(wr_cnt) - CW'(pop);
    end
  end

  assign head_data = mem_r[head_r];
  assign head_ptr  = head_r;
  assign count     = count_r;
  assign entries   = mem_r;

endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: buffers ALU and load results and drains them one per cycle
// into the single regfile write port.
//   alu_valid/alu_reg/alu_data/alu_ready : ALU result handshake
//   mem_valid/mem_reg/mem_data/mem_ready : load result handshake (wins ties)
//   regWrite/writeReg/writeData          : regfile write port, head of queue
//   readReg1/readReg2                    : regfile read indices for bypass
//   fwdN_hit/fwdN_data                   : youngest pending write to readRegN
//   count                                : occupied entries
// Build option: define WBQ_BYPASS_EN to build the forwarding lookup; without
// it the fwd outputs are tied to zero and no compare logic exists.
module writeback_queue import wbq_pkg::*; #(
  parameter int DEPTH  = WBQ_DEPTH,
  parameter int DATA_W = WBQ_DATA_W,
  parameter int ADDR_W = WBQ_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_reg,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [ADDR_W-1:0]      mem_reg,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   mem_ready,
  output logic                   regWrite,
  output logic [ADDR_W-1:0]      writeReg,
  output logic [DATA_W-1:0]      writeData,
  input  logic [ADDR_W-1:0]      readReg1,
  input  logic [ADDR_W-1:0]      readReg2,
  output logic                   fwd1_hit,
  output logic                   fwd2_hit,
  output logic [DATA_W-1:0]      fwd1_data,
  output logic [DATA_W-1:0]      fwd2_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = CW + 1;
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] ZERO_R = ADDR_W'(ZERO_REG);

  logic [CW-1:0]           count_s;
  logic [FW-1:0]           free_s;
  logic                    nonempty_s;
  logic [EW-1:0]           head_s;
  logic [PW-1:0]           head_ptr_s;
  logic [DEPTH-1:0][EW-1:0] entries_s;
  logic                    alu_zero_s;
  logic                    mem_zero_s;
  logic                    alu_rdy_s;
  logic                    mem_rdy_s;
  logic                    alu_store_s;
  logic                    mem_store_s;
  logic [1:0]              wr_cnt_s;
  logic [EW-1:0]           wr0_s;
  logic [EW-1:0]           wr1_s;

  assign nonempty_s = (count_s != '0);
  // The head leaves this cycle, so its slot is usable by an incoming write.
  assign free_s     = FW'(DEPTH) - FW'(count_s) + FW'(nonempty_s);
  assign alu_zero_s = (alu_reg == ZERO_R);
  assign mem_zero_s = (mem_reg == ZERO_R);

  // Ready arbitration: memory wins the last slot; X31 needs no slot at all.
  always_comb begin
    alu_rdy_s = 1'b0;
    mem_rdy_s = 1'b0;
    if (free_s >= FW'(2)) begin
      alu_rdy_s = 1'b1;
      mem_rdy_s = 1'b1;
    end else if (free_s == FW'(1)) begin
      mem_rdy_s = 1'b1;
      alu_rdy_s = !mem_valid;
    end else begin
      alu_rdy_s = alu_zero_s;
      mem_rdy_s = mem_zero_s;
    end
  end

  assign alu_ready   = alu_rdy_s;
  assign mem_ready   = mem_rdy_s;
  assign alu_store_s = alu_valid && alu_rdy_s && !alu_zero_s;
  assign mem_store_s = mem_valid && mem_rdy_s && !mem_zero_s;

  // Enqueue steering: the load entry goes ahead of the ALU entry.
  always_comb begin
    wr_cnt_s = 2'd0;
    wr0_s    = {mem_reg, mem_data};
    wr1_s    = {alu_reg, alu_data};
    if (mem_store_s && alu_store_s) begin
      wr_cnt_s = 2'd2;
    end else if (mem_store_s) begin
      wr_cnt_s = 2'd1;
    end else if (alu_store_s) begin
      wr_cnt_s = 2'd1;
      wr0_s    = {alu_reg, alu_data};
    end else begin
      wr_cnt_s = 2'd0;
    end
  end

  wbq_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_cnt    (wr_cnt_s),
    .wr_data0  (wr0_s),
    .wr_data1  (wr1_s),
    .pop       (nonempty_s),
    .head_data (head_s),
    .head_ptr  (head_ptr_s),
    .count     (count_s),
    .entries   (entries_s)
  );

  // Stale storage is masked so the write port reads zero while empty.
  assign regWrite  = nonempty_s;
  assign writeReg  = nonempty_s ? head_s[EW-1:DATA_W] : '0;
  assign writeData = nonempty_s ? head_s[DATA_W-1:0] : '0;
  assign count     = count_s;

`ifdef WBQ_BYPASS_EN
  // Bypass lookup: walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx_v;
    logic [EW-1:0] ent_v;
    logic          vld_v;
    logic          m1_v;
    logic          m2_v;
    idx_v     = '0;
    ent_v     = '0;
    vld_v     = 1'b0;
    m1_v      = 1'b0;
    m2_v      = 1'b0;
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_v     = head_ptr_s + PW'(k);
      ent_v     = entries_s[idx_v];
      vld_v     = (CW'(k) < count_s);
      m1_v      = vld_v && (ent_v[EW-1:DATA_W] == readReg1) && (readReg1 != ZERO_R);
      m2_v      = vld_v && (ent_v[EW-1:DATA_W] == readReg2) && (readReg2 != ZERO_R);
      fwd1_hit  = fwd1_hit | m1_v;
      fwd2_hit  = fwd2_hit | m2_v;
      fwd1_data = m1_v ? ent_v[DATA_W-1:0] : fwd1_data;
      fwd2_data = m2_v ? ent_v[DATA_W-1:0] : fwd2_data;
    end
  end
`else
  logic unused_bypass_s;
  assign unused_bypass_s = ^{readReg1, readReg2, head_ptr_s, entries_s};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed self-checking bench for writeback_queue
// (DEPTH=4). Inputs change 1 time unit after a rising edge; outputs are
// compared mid-cycle.
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_reg, mem_reg, readReg1, readReg2, writeReg;
  logic [63:0] alu_data, mem_data, writeData, fwd1_data, fwd2_data;
  logic        alu_ready, mem_ready, regWrite, fwd1_hit, fwd2_hit;
  logic [2:0]  count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int x31_seen = 0;

  writeback_queue #(.DEPTH(4), .DATA_W(64), .ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readReg1(readReg1), .readReg2(readReg2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reset_n === 1'b1 && regWrite === 1'b1 && writeReg === 5'd31) x31_seen++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 64'd0;
    mem_valid = 1'b0; mem_reg = 5'd0; mem_data = 64'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; readReg1 = 5'd0; readReg2 = 5'd0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (regWrite !== 1'b0) $display("FAIL rst_we got %0b want 0", regWrite); else pass_cnt++;
    total_cnt++; if (count !== 3'd0) $display("FAIL rst_count got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (writeData !== 64'd0 || writeReg !== 5'd0) $display("FAIL rst_wport got %0d/%h want 0/0", writeReg, writeData); else pass_cnt++;
    reset_n = 1'b1;
    #1;
    total_cnt++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) $display("FAIL rst_ready got %0b%0b want 11", alu_ready, mem_ready); else pass_cnt++;
    total_cnt++; if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0 || fwd1_data !== 64'd0) $display("FAIL rst_fwd got %0b%0b %h want 00 0", fwd1_hit, fwd2_hit, fwd1_data); else pass_cnt++;
  endtask

  task automatic test_single_alu();
    step();
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 64'hDEAD_BEEF;
    #1;
    total_cnt++; if (alu_ready !== 1'b1) $display("FAIL single_ready got %0b want 1", alu_ready); else pass_cnt++;
    total_cnt++; if (regWrite !== 1'b0) $display("FAIL single_early got %0b want 0", regWrite); else pass_cnt++;
    step();
    idle();
    #1;
    total_cnt++; if (regWrite !== 1'b1 || writeReg !== 5'd5) $display("FAIL single_wr got %0b/%0d want 1/5", regWrite, writeReg); else pass_cnt++;
    total_cnt++; if (writeData !== 64'hDEAD_BEEF) $display("FAIL single_data got %h want deadbeef", writeData); else pass_cnt++;
    total_cnt++; if (count !== 3'd1) $display("FAIL single_count got %0d want 1", count); else pass_cnt++;
    step();
    total_cnt++; if (regWrite !== 1'b0 || count !== 3'd0) $display("FAIL single_after got %0b/%0d want 0/0", regWrite, count); else pass_cnt++;
  endtask

  task automatic test_dual_enqueue();
    mem_valid = 1'b1; mem_reg = 5'd1; mem_data = 64'h11;
    alu_valid = 1'b1; alu_reg = 5'd2; alu_data = 64'h22;
    step();
    idle();
    #1;
    total_cnt++; if (writeReg !== 5'd1 || writeData !== 64'h11 || regWrite !== 1'b1) $display("FAIL dual_first got %0d/%h want 1/11", writeReg, writeData); else pass_cnt++;
    total_cnt++; if (count !== 3'd2) $display("FAIL dual_count got %0d want 2", count); else pass_cnt++;
    step();
    total_cnt++; if (writeReg !== 5'd2 || writeData !== 64'h22 || regWrite !== 1'b1) $display("FAIL dual_second got %0d/%h want 2/22", writeReg, writeData); else pass_cnt++;
    step();
    total_cnt++; if (regWrite !== 1'b0) $display("FAIL dual_empty got %0b want 0", regWrite); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp_reg[$];
    logic [63:0] exp_dat[$];
    int          exp_cnt[6] = '{0, 2, 3, 4, 4, 4};
    bit          exp_alu[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int          drained = 0;
    for (int c = 0; c < 6; c++) begin
      mem_valid = 1'b1; mem_reg = 5'(10 + 2 * c); mem_data = 64'hA000_0000_0000_0000 | 64'(10 + 2 * c);
      alu_valid = 1'b1; alu_reg = 5'(11 + 2 * c); alu_data = 64'hB000_0000_0000_0000 | 64'(11 + 2 * c);
      #1;
      total_cnt++; if (count !== 3'(exp_cnt[c])) $display("FAIL b2b_count c%0d got %0d want %0d", c, count, exp_cnt[c]); else pass_cnt++;
      total_cnt++; if (alu_ready !== exp_alu[c] || mem_ready !== 1'b1) $display("FAIL b2b_ready c%0d got %0b%0b want %0b1", c, alu_ready, mem_ready, exp_alu[c]); else pass_cnt++;
      if (exp_reg.size() > 0) begin
        total_cnt++; if (regWrite !== 1'b1 || writeReg !== exp_reg[0] || writeData !== exp_dat[0]) $display("FAIL b2b_wr c%0d got %0d/%h want %0d/%h", c, writeReg, writeData, exp_reg[0], exp_dat[0]); else pass_cnt++;
        void'(exp_reg.pop_front()); void'(exp_dat.pop_front());
      end
      exp_reg.push_back(mem_reg); exp_dat.push_back(mem_data);
      if (exp_alu[c]) begin
        exp_reg.push_back(alu_reg); exp_dat.push_back(alu_data);
      end
      step();
    end
    idle();
    #1;
    for (int k = 0; k < 12 && exp_reg.size() > 0; k++) begin
      total_cnt++; if (regWrite !== 1'b1 || writeReg !== exp_reg[0] || writeData !== exp_dat[0]) $display("FAIL drain_wr k%0d got %0d/%h want %0d/%h", k, writeReg, writeData, exp_reg[0], exp_dat[0]); else pass_cnt++;
      void'(exp_reg.pop_front()); void'(exp_dat.pop_front());
      drained++;
      step();
    end
    total_cnt++; if (drained !== 4) $display("FAIL drain_len got %0d want 4", drained); else pass_cnt++;
    total_cnt++; if (regWrite !== 1'b0 || count !== 3'd0) $display("FAIL drain_end got %0b/%0d want 0/0", regWrite, count); else pass_cnt++;
  endtask

  task automatic test_x31();
    alu_valid = 1'b1; alu_reg = 5'd31; alu_data = 64'h55;
    #1;
    total_cnt++; if (alu_ready !== 1'b1) $display("FAIL x31_ready got %0b want 1", alu_ready); else pass_cnt++;
    step();
    idle();
    #1;
    total_cnt++; if (count !== 3'd0 || regWrite !== 1'b0) $display("FAIL x31_drop got %0d/%0b want 0/0", count, regWrite); else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      mem_valid = 1'b1; mem_reg = 5'(20 + 2 * c); mem_data = 64'(c);
      alu_valid = 1'b1; alu_reg = 5'(21 + 2 * c); alu_data = 64'(c);
      step();
    end
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_reg = 5'd31; alu_data = 64'h55;
    #1;
    total_cnt++; if (count !== 3'd4 || alu_ready !== 1'b1) $display("FAIL x31_full got %0d/%0b want 4/1", count, alu_ready); else pass_cnt++;
    step();
    total_cnt++; if (count !== 3'd3) $display("FAIL x31_full_count got %0d want 3", count); else pass_cnt++;
    mem_valid = 1'b1; mem_reg = 5'd31; mem_data = 64'h66;
    alu_valid = 1'b1; alu_reg = 5'd25; alu_data = 64'h77;
    #1;
    total_cnt++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) $display("FAIL x31_mem_ready got %0b%0b want 11", mem_ready, alu_ready); else pass_cnt++;
    step();
    idle();
    total_cnt++; if (count !== 3'd3) $display("FAIL x31_mem_count got %0d want 3", count); else pass_cnt++;
    repeat (4) step();
    total_cnt++; if (count !== 3'd0) $display("FAIL x31_drain got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (x31_seen !== 0) $display("FAIL x31_write got %0d want 0", x31_seen); else pass_cnt++;
  endtask

  task automatic test_bypass();
    logic        exp_hit;
    logic [63:0] exp_dat;
`ifdef WBQ_BYPASS_EN
    exp_hit = 1'b1; exp_dat = 64'hB;
`else
    exp_hit = 1'b0; exp_dat = 64'h0;
`endif
    readReg1 = 5'd7; readReg2 = 5'd31;
    mem_valid = 1'b1; mem_reg = 5'd7; mem_data = 64'hA;
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 64'hB;
    step();
    idle();
    #1;
    total_cnt++; if (fwd1_hit !== exp_hit || fwd1_data !== exp_dat) $display("FAIL byp_young got %0b/%h want %0b/%h", fwd1_hit, fwd1_data, exp_hit, exp_dat); else pass_cnt++;
    total_cnt++; if (fwd2_hit !== 1'b0 || fwd2_data !== 64'd0) $display("FAIL byp_x31 got %0b/%h want 0/0", fwd2_hit, fwd2_data); else pass_cnt++;
    total_cnt++; if (writeReg !== 5'd7 || writeData !== 64'hA) $display("FAIL byp_head got %0d/%h want 7/a", writeReg, writeData); else pass_cnt++;
    readReg2 = 5'd9;
    step();
    total_cnt++; if (fwd1_hit !== exp_hit || fwd1_data !== exp_dat) $display("FAIL byp_last got %0b/%h want %0b/%h", fwd1_hit, fwd1_data, exp_hit, exp_dat); else pass_cnt++;
    total_cnt++; if (fwd2_hit !== 1'b0) $display("FAIL byp_miss got %0b want 0", fwd2_hit); else pass_cnt++;
    step();
    total_cnt++; if (fwd1_hit !== 1'b0 || fwd1_data !== 64'd0) $display("FAIL byp_empty got %0b/%h want 0/0", fwd1_hit, fwd1_data); else pass_cnt++;
    readReg1 = 5'd0; readReg2 = 5'd0;
  endtask

  task automatic test_reset_mid_drain();
    mem_valid = 1'b1; mem_reg = 5'd3; mem_data = 64'h3;
    alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 64'h4;
    step();
    mem_reg = 5'd6; mem_data = 64'h6;
    alu_reg = 5'd8; alu_data = 64'h8;
    step();
    idle();
    total_cnt++; if (count !== 3'd3 || regWrite !== 1'b1) $display("FAIL mid_fill got %0d/%0b want 3/1", count, regWrite); else pass_cnt++;
    #1;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (regWrite !== 1'b0 || writeReg !== 5'd0 || writeData !== 64'd0) $display("FAIL mid_async got %0b/%0d/%h want 0/0/0", regWrite, writeReg, writeData); else pass_cnt++;
    total_cnt++; if (count !== 3'd0) $display("FAIL mid_count got %0d want 0", count); else pass_cnt++;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    total_cnt++; if (regWrite !== 1'b0 || count !== 3'd0) $display("FAIL mid_after got %0b/%0d want 0/0", regWrite, count); else pass_cnt++;
    total_cnt++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) $display("FAIL mid_ready got %0b%0b want 11", alu_ready, mem_ready); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_dual_enqueue();
    test_back_to_back();
    test_x31();
    test_bypass();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
